// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
//   Load/store port bundle between a SCRISC-16 initiator and a data-memory
//   responder.
//
//   Request channel  : req_valid / req_ready handshake carrying
//                      req_we (1 = store), req_addr (byte address), req_wdata.
//   Response channel : resp_valid / resp_ready handshake carrying
//                      resp_rdata (load data) and resp_err.
//
//   Modports:
//     master - the initiator (core side)
//     slave  - the responder (memory side)
// ---------------------------------------------------------------------------
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Word-addressed data memory behind a valid/ready request/response port.
//   One request is outstanding at a time. After acceptance, the access is
//   performed following WAIT_STATES extra cycles. The result is then held on
//   the response channel until the initiator takes it.
//
//   Parameters:
//     DEPTH_WORDS - number of 16-bit words (word index 0..DEPTH_WORDS-1)
//     WAIT_STATES - extra cycles before each access executes (0..15)
//
//   Ports:
//     clk       - clock, all state changes on the rising edge
//     reset     - asynchronous active-low reset; clears state and memory
//     bus       - request/response handshake (slave side)
//     txn_count - number of consumed responses, wraps at 16 bits
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                reset,
    dmem_responder_if.slave     bus,
    output logic [15:0]         txn_count
);

    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;

    logic        lat_we_reg;
    logic [15:0] lat_addr_reg;
    logic [15:0] lat_wdata_reg;

    logic [15:0] resp_rdata_reg;
    logic        resp_err_reg;
    logic [15:0] txn_count_reg;

    logic [15:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        execute;
    logic        release_txn;
    logic        addr_ok;
    logic        mem_we;
    logic [14:0] word_index;
    logic [AW-1:0] mem_idx;

    // Address decode works on the latched request so it is stable for the
    // whole ACCESS phase regardless of what the initiator does meanwhile.
    assign word_index = lat_addr_reg[15:1];
    assign addr_ok    = ~lat_addr_reg[0] && (32'(word_index) < DEPTH_WORDS);
    assign mem_idx    = word_index[AW-1:0];
    assign mem_we     = execute && lat_we_reg && addr_ok;

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        accept        = 1'b0;
        execute       = 1'b0;
        release_txn   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    accept        = 1'b1;
                    wait_cnt_next = WAIT_INIT;
                    state_next    = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_cnt_reg == 4'd0) begin
                    execute    = 1'b1;
                    state_next = RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    release_txn = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- control / datapath registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= 4'd0;
            lat_we_reg     <= 1'b0;
            lat_addr_reg   <= 16'd0;
            lat_wdata_reg  <= 16'd0;
            resp_rdata_reg <= 16'd0;
            resp_err_reg   <= 1'b0;
            txn_count_reg  <= 16'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (accept) begin
                lat_we_reg    <= bus.req_we;
                lat_addr_reg  <= bus.req_addr;
                lat_wdata_reg <= bus.req_wdata;
            end
            if (execute) begin
                resp_err_reg <= ~addr_ok;
                // Stores and rejected requests return zero data.
                if (addr_ok && !lat_we_reg) begin
                    resp_rdata_reg <= mem[mem_idx];
                end else begin
                    resp_rdata_reg <= 16'd0;
                end
            end
            if (release_txn) begin
                txn_count_reg <= txn_count_reg + 16'd1;
            end
        end
    end

    // ---------------- storage ----------------
    // Each word has its own register so the whole array can be cleared by
    // the asynchronous reset.
    for (genvar gi = 0; gi < DEPTH_WORDS; gi++) begin : g_word
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mem[gi] <= 16'd0;
            end else if (mem_we && (mem_idx == AW'(gi))) begin
                mem[gi] <= lat_wdata_reg;
            end
        end
    end

    // ---------------- outputs (decoded from registers only) ----------------
    assign bus.req_ready  = (state_reg == IDLE);
    assign bus.resp_valid = (state_reg == RESP);
    assign bus.resp_rdata = resp_rdata_reg;
    assign bus.resp_err   = resp_err_reg;
    assign txn_count      = txn_count_reg;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data-memory responder for the SCRISC-16 core's load/store port. It accepts one request at a time over a valid/ready handshake and performs the read or write after a programmable number of wait states. It returns the result over a second valid/ready handshake. It lets the core (or a multi-cycle core variant) talk to data memory as a latency-tolerant initiator instead of through a combinational memory.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 16-bit words stored; legal word indices 0..DEPTH_WORDS-1.
- WAIT_STATES, 1: extra cycles inserted before each access completes; range 0..15.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  16  byte address; bit 0 must be 0.
- req_wdata  in  16  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  initiator takes the response.
- resp_rdata  out  16  load data; 0 for stores and errors.
- resp_err  out  1  request was misaligned or out of range.
- txn_count  out  16  number of completed handshakes (responses consumed), wraps.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted on an edge with req_valid=1. On that edge, req_we, req_addr and req_wdata are latched and the block moves to ACCESS. The wait counter loads with WAIT_STATES.
- ACCESS:
  - req_ready=0.
  - The counter decrements each cycle while nonzero.
  - On the edge where the counter is 0, the latched access executes and the block moves to RESP.
  - ACCESS therefore lasts WAIT_STATES+1 cycles.
- Access execution:
  - Word index = addr[15:1].
  - Error if addr[0]=1 or index ≥ DEPTH_WORDS.
  - Error: memory unchanged, resp_rdata=0, resp_err=1.
  - Store OK: mem[index] ← wdata, resp_rdata=0, resp_err=0.
  - Load OK: resp_rdata ← mem[index], resp_err=0.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - On an edge with resp_ready=1: txn_count increments (16-bit wrap, 0xFFFF→0x0000) and the block returns to IDLE.
  - With resp_ready=0 the block stays in RESP indefinitely.
- Requests presented outside IDLE are ignored (req_ready=0); the initiator must hold them.
- Memory array: all words cleared to 0 on reset.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, txn_count=0, state IDLE, memory all 0.
- Reset is asynchronous and active-low:
  - Asserting reset in any state aborts the transaction; a store not yet executed is lost.
  - A store already executed stays lost too, because memory is cleared.
  - After release, the first accept is possible on the first rising edge with reset=1.
- Latency: request accepted on edge k → resp_valid=1 from edge k+WAIT_STATES+1. A store is visible in memory from that same edge.
- Throughput: with resp_ready held 1, one transaction per WAIT_STATES+3 cycles. Accept, access and release each consume an edge; req_ready returns on the edge resp_valid drops.
- resp_valid and req_ready are never both 1.
- Outputs are registered. No combinational path from req_* or resp_ready to any output.
- A load from an address is ordered after any prior store to it (single outstanding request).

## Test plan
- Reset then idle: hold reset=0 for 3 cycles, release → req_ready=1, resp_valid=0, txn_count=0. Load 0x0000 returns resp_rdata=0x0000, resp_err=0.
- Store/load, WAIT_STATES=1: store 0xBEEF to 0x0010, then load 0x0010.
  - Each resp_valid rises exactly 2 cycles after its accept edge.
  - The load returns 0xBEEF, resp_err=0; txn_count=2.
- Errors:
  - Store 0x1234 to 0x0011 (misaligned) → resp_err=1.
  - Load 0x0200 with DEPTH_WORDS=256 (index 256) → resp_err=1, resp_rdata=0.
  - A following load of 0x0010 still returns its prior value.
- Backpressure: complete a load of a word holding 0xA5A5, keep resp_ready=0 for 5 cycles.
  - resp_valid stays 1 and resp_rdata stays 0xA5A5; req_ready stays 0 despite req_valid=1.
  - Raising resp_ready completes the load; txn_count increments once.
- Reset mid-operation (WAIT_STATES=3): accept store 0x5555 to 0x0004, assert reset during ACCESS cycle 2.
  - Outputs return to reset values immediately.
  - A later load of 0x0004 returns 0x0000.
- WAIT_STATES=0 back-to-back: issue 4 stores then 4 loads with resp_ready=1.
  - Each response arrives 1 cycle after accept; transactions complete every 3 cycles.
  - Data matches what was stored; txn_count=8.
